// File: rtl/i_cache_direct.sv
// i_cache_direct -- direct-mapped, read-only instruction cache.
//
// Sits between the CPU fetch port and the 4-word line-read memory port.
// A hit returns the requested word combinationally in the same cycle.
// A miss latches the line-aligned address, holds readM1 for MEM_LATENCY
// cycles, and installs the returned line on the final FILL posedge.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cpu_read, cpu_address   fetch request and word address
//   cpu_data, cpu_ready     fetched word, valid when cpu_ready=1 (hit)
//   flush                   invalidate all lines on the next posedge
//   readM1, address1        memory line-read request and line address
//   data1_1..data1_4        line words at address1+0..+3
//   num_hit, num_miss       16-bit wrapping hit / miss counters
module i_cache_direct #(
   parameter int WORD_SIZE   = 16,
   parameter int NUM_LINES   = 4,
   parameter int MEM_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cpu_read,
   input  logic [WORD_SIZE-1:0] cpu_address,
   output logic [WORD_SIZE-1:0] cpu_data,
   output logic                 cpu_ready,
   input  logic                 flush,
   output logic                 readM1,
   output logic [WORD_SIZE-1:0] address1,
   input  logic [WORD_SIZE-1:0] data1_1,
   input  logic [WORD_SIZE-1:0] data1_2,
   input  logic [WORD_SIZE-1:0] data1_3,
   input  logic [WORD_SIZE-1:0] data1_4,
   output logic [15:0]          num_hit,
   output logic [15:0]          num_miss
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = WORD_SIZE - 2 - IDX_W;
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t                 state_q, state_d;
   logic [NUM_LINES-1:0]   valid_q, valid_d;
   // Line address (word address >> 2) of the line being filled.
   logic [WORD_SIZE-3:0]   fill_line_q, fill_line_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [15:0]            num_hit_q, num_hit_d;
   logic [15:0]            num_miss_q, num_miss_d;

   // Tag and data storage are not reset: valid_q gates every use of them.
   logic [TAG_W-1:0]       tag_q  [NUM_LINES];
   logic [WORD_SIZE-1:0]   data_q [NUM_LINES][4];

   logic [1:0]             req_off;
   logic [IDX_W-1:0]       req_idx, fill_idx;
   logic [TAG_W-1:0]       req_tag, fill_tag;
   logic                   hit, fill_done;

   assign req_off  = cpu_address[1:0];
   assign req_idx  = cpu_address[2 +: IDX_W];
   assign req_tag  = cpu_address[WORD_SIZE-1 -: TAG_W];
   assign fill_idx = fill_line_q[IDX_W-1:0];
   assign fill_tag = fill_line_q[WORD_SIZE-3 -: TAG_W];

   assign hit = (state_q == IDLE) && cpu_read && !flush &&
                valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   // Last FILL cycle: the line is written on the posedge that ends it.
   assign fill_done = (state_q == FILL) && (cnt_q == LAST_CNT);

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      fill_line_d = fill_line_q;
      cnt_d       = cnt_q;
      num_hit_d   = num_hit_q;
      num_miss_d  = num_miss_q;
      cpu_ready   = 1'b0;
      cpu_data    = '0;
      readM1      = 1'b0;
      address1    = '0;

      // Flush clears first so a fill completing on the same edge still
      // leaves its own line valid.
      if (flush) begin
         valid_d = '0;
      end

      case (state_q)
         IDLE: begin
            if (hit) begin
               cpu_ready = 1'b1;
               cpu_data  = data_q[req_idx][req_off];
               num_hit_d = num_hit_q + 16'd1;
            end else if (cpu_read && !flush) begin
               state_d     = FILL;
               fill_line_d = cpu_address[WORD_SIZE-1:2];
               cnt_d       = '0;
               num_miss_d  = num_miss_q + 16'd1;
            end
         end
         FILL: begin
            readM1   = 1'b1;
            address1 = {fill_line_q, 2'b00};
            if (fill_done) begin
               state_d           = IDLE;
               valid_d[fill_idx] = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         fill_line_q <= '0;
         cnt_q       <= '0;
         num_hit_q   <= '0;
         num_miss_q  <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         fill_line_q <= fill_line_d;
         cnt_q       <= cnt_d;
         num_hit_q   <= num_hit_d;
         num_miss_q  <= num_miss_d;
      end
   end

   // Line install. Reset forces state_q to IDLE, so an abandoned fill
   // never reaches this write.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tag_q[fill_idx]     <= fill_tag;
         data_q[fill_idx][0] <= data1_1;
         data_q[fill_idx][1] <= data1_2;
         data_q[fill_idx][2] <= data1_3;
         data_q[fill_idx][3] <= data1_4;
      end
   end

   assign num_hit  = num_hit_q;
   assign num_miss = num_miss_q;

endmodule

// File: tb/tb_i_cache_direct.sv
// Testbench for i_cache_direct: directed scenarios plus randomized fetches,
// all compared cycle by cycle against a line-level reference model.
module tb_i_cache_direct;
   localparam int NL  = 4;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_read = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] cpu_address = '0;
   logic [15:0] cpu_data;
   logic        cpu_ready;
   logic        readM1;
   logic [15:0] address1;
   logic [15:0] data1_1, data1_2, data1_3, data1_4;
   logic [15:0] num_hit, num_miss;

   always #5 clk = ~clk;

   // Memory: word at address A is A ^ 16'hA5A5.
   assign data1_1 = (address1 + 16'd0) ^ 16'hA5A5;
   assign data1_2 = (address1 + 16'd1) ^ 16'hA5A5;
   assign data1_3 = (address1 + 16'd2) ^ 16'hA5A5;
   assign data1_4 = (address1 + 16'd3) ^ 16'hA5A5;

   i_cache_direct #(.WORD_SIZE(16), .NUM_LINES(NL), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset_n(reset_n), .cpu_read(cpu_read), .cpu_address(cpu_address),
      .cpu_data(cpu_data), .cpu_ready(cpu_ready), .flush(flush),
      .readM1(readM1), .address1(address1),
      .data1_1(data1_1), .data1_2(data1_2), .data1_3(data1_3), .data1_4(data1_4),
      .num_hit(num_hit), .num_miss(num_miss)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: which line base address each slot holds, and how many
   // fill cycles remain (0 = ready to serve fetches).
   bit          m_valid [NL];
   logic [15:0] m_base  [NL];
   int          m_fill_left;
   logic [15:0] m_fill_addr;
   logic [15:0] m_hits, m_misses;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      m_fill_left = 0;
      m_fill_addr = '0;
      m_hits      = '0;
      m_misses    = '0;
   endfunction

   function automatic bit model_hit();
      int idx = int'((cpu_address >> 2) % NL);
      return (m_fill_left == 0) && cpu_read && !flush && m_valid[idx] &&
             (m_base[idx] == (cpu_address & 16'hFFFC));
   endfunction

   // One clock cycle: inputs already applied (called just after negedge).
   task automatic cycle(output bit ready_seen);
      bit h;
      int idx;
      h = model_hit();
      #1;
      ready_seen = cpu_ready;
      check_eq("cpu_ready", cpu_ready, h);
      if (h) check_eq("cpu_data", cpu_data, cpu_address ^ 16'hA5A5);
      check_eq("readM1", readM1, m_fill_left > 0);
      check_eq("address1", address1, (m_fill_left > 0) ? m_fill_addr : 16'h0000);
      check_eq("num_hit", num_hit, m_hits);
      check_eq("num_miss", num_miss, m_misses);
      @(posedge clk);
      if (flush) for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      if (m_fill_left > 0) begin
         m_fill_left--;
         if (m_fill_left == 0) begin
            idx = int'((m_fill_addr >> 2) % NL);
            m_valid[idx] = 1'b1;
            m_base[idx]  = m_fill_addr;
         end
      end else if (h) begin
         m_hits++;
      end else if (cpu_read && !flush) begin
         m_misses++;
         m_fill_addr = cpu_address & 16'hFFFC;
         m_fill_left = LAT;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      cpu_read = 1'b0;
      flush    = 1'b0;
      model_reset();
      #1;
      check_eq("rst_readM1", readM1, 1'b0);
      check_eq("rst_address1", address1, 16'h0000);
      check_eq("rst_cpu_ready", cpu_ready, 1'b0);
      check_eq("rst_cpu_data", cpu_data, 16'h0000);
      check_eq("rst_num_hit", num_hit, 16'h0000);
      check_eq("rst_num_miss", num_miss, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Hold a fetch until the DUT reports a hit (bounded), then check the
   // observed number of cycles spent before the hit.
   task automatic fetch(input logic [15:0] addr, input int exp_lat);
      bit seen;
      bit got;
      int lat;
      cpu_read    = 1'b1;
      cpu_address = addr;
      flush       = 1'b0;
      got = 1'b0;
      lat = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         cycle(seen);
         if (seen) got = 1'b1;
         else      lat++;
      end
      check_eq("fetch_hit_seen", got, 1'b1);
      check_eq("fetch_latency", lat, exp_lat);
      $display("fetch addr=%h latency=%0d", addr, lat);
   endtask

   initial begin
      bit r;
      model_reset();
      @(negedge clk);
      do_reset();

      // Cold miss then line reuse.
      fetch(16'h0005, 3);
      check_eq("cold_num_miss", num_miss, 16'd1);
      fetch(16'h0004, 0);
      fetch(16'h0006, 0);
      fetch(16'h0007, 0);
      check_eq("reuse_num_hit", num_hit, 16'd4);

      // Conflict on index 1.
      fetch(16'h0014, 3);
      fetch(16'h0004, 3);
      check_eq("conflict_num_miss", num_miss, 16'd3);

      // Flush during the first FILL cycle.
      cpu_read = 1'b1; cpu_address = 16'h0008;
      cycle(r);
      flush = 1'b1;
      cycle(r);
      flush = 1'b0;
      fetch(16'h0008, 1);
      fetch(16'h0004, 3);

      // Reset in the second FILL cycle.
      cpu_read = 1'b1; cpu_address = 16'h000C;
      cycle(r);
      cycle(r);
      do_reset();
      fetch(16'h000C, 3);
      check_eq("post_reset_num_miss", num_miss, 16'd1);

      // Randomized traffic with conflicts, flushes and wide tags.
      for (int i = 0; i < 3000; i++) begin
         cpu_read    = ($urandom_range(0, 3) != 0);
         cpu_address = 16'($urandom) & (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'h003F);
         flush       = ($urandom_range(0, 29) == 0);
         cycle(r);
      end
      flush = 1'b0;

      // Hit counter wrap: 65536 hits in total after reset.
      do_reset();
      fetch(16'h0008, 3);
      cpu_read = 1'b1; cpu_address = 16'h0008;
      for (int i = 0; i < 65535; i++) cycle(r);
      check_eq("wrap_num_hit", num_hit, 16'h0000);
      check_eq("wrap_num_miss", num_miss, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/i_cache_direct.md
# i_cache_direct

Direct-mapped, read-only instruction cache between the CPU fetch port and memory port 1 (the 4-word line-read port: readM1, address1, data1_1..data1_4). Hits return a 16-bit instruction word in the same cycle. Misses issue one line read, wait a fixed memory latency, install the 4-word line, then hit. Hit and miss counters are exported for the bench's debug checks, alongside num_inst.

## Interface
- WORD_SIZE, 16, data and address width (word-addressed)
- NUM_LINES, 4, number of cache lines; power of two, ≥2
- MEM_LATENCY, 2, cycles readM1 is held before the line data is valid; ≥1
- clk  input  1  clock; all state updates on posedge
- reset_n  input  1  asynchronous, active-low reset
- cpu_read  input  1  fetch request
- cpu_address  input  WORD_SIZE  fetch word address
- cpu_data  output  WORD_SIZE  fetched word; valid only when cpu_ready=1
- cpu_ready  output  1  hit: cpu_data valid this cycle
- flush  input  1  invalidate all lines
- readM1  output  1  memory line-read request
- address1  output  WORD_SIZE  line-aligned read address (low 2 bits = 0)
- data1_1..data1_4  input  WORD_SIZE each  words at address1+0..+3
- num_hit  output  16  hit counter
- num_miss  output  16  miss counter

## Operation
- Address split: offset = addr[1:0]; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Per line: valid bit, tag, 4 data words.
- States: IDLE, FILL.
- IDLE: hit = cpu_read & valid[index] & tag match & !flush. Hit: cpu_ready=1, cpu_data = line word[offset] (combinational). Miss (cpu_read & !hit & !flush): latch line-aligned address into fill register, go to FILL, increment num_miss.
- FILL: readM1=1 and address1 = fill register for exactly MEM_LATENCY cycles; cpu_ready=0. On the posedge ending the last FILL cycle: write data1_1..4 into the line, set valid, write tag, return to IDLE.
- cpu_address or cpu_read changing during FILL is ignored; the latched fill always completes.
- flush (any state): all valid bits cleared on the next posedge. If flush occurs during FILL, the fill still completes and its line ends up valid. In IDLE, flush suppresses hit and miss for that cycle.
- num_hit increments on every IDLE cycle with a hit. Both counters are 16-bit and wrap 0xFFFF→0x0000.
- readM1=0 and address1=0 outside FILL.

## Timing
- Reset (async, reset_n=0): state=IDLE, all valid=0, num_hit=num_miss=0, readM1=0, address1=0, cpu_ready=0. cpu_data is don't-care while cpu_ready=0 and is driven 0 here.
- Hit latency: 0 cycles, combinational from cpu_address.
- Miss penalty: request in cycle t (miss) → FILL in t+1..t+MEM_LATENCY → IDLE at t+MEM_LATENCY+1, hit asserted that cycle if the request is still held. Default MEM_LATENCY=2 gives cpu_ready at t+3.
- data1_* sampled only on the final FILL posedge.
- Reset mid-FILL: fill abandoned, no line written, readM1 drops immediately.
- Same-index different-tag access: miss; the line is replaced (no associativity).

## Test plan
- Bench memory model: word at address A = A ^ 16'hA5A5, MEM_LATENCY=2, NUM_LINES=4.
- Cold miss: reset, then read 0x0005 → readM1=1 and address1=0x0004 for 2 cycles, then cpu_ready=1 with cpu_data=0xA5A0; num_miss=1.
- Line reuse: then read 0x0004, 0x0006, 0x0007 → each returns a 0-cycle hit (0xA5A1, 0xA5A3, 0xA5A2); num_hit=4 including the post-fill hit of 0x0005.
- Conflict: read 0x0014 (same index as 0x0004, different tag) → miss, 2-cycle fill at 0x0014. Then read 0x0004 → miss again; num_miss=3.
- Flush during FILL: miss on 0x0008, assert flush in the 1st FILL cycle → fill completes and 0x0008 hits. Then 0x0004, previously valid, misses.
- Reset mid-FILL: miss on 0x000C, pull reset_n low in the 2nd FILL cycle → readM1=0 at once, counters=0. After release, 0x000C misses again.
- Counter wrap: 65536 hits on 0x0008 → num_hit wraps to 0x0000 without affecting num_miss.
